// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count, registered status flags,
// sticky overflow/underflow, and a choice of registered or fall-through read data.
`timescale 1ns/1ps

module sync_fifo #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_SIZE  = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 winc,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  typedef logic [ADDR_SIZE:0] ptr_t;

  localparam ptr_t FULL_CNT   = ptr_t'(DEPTH);
  localparam ptr_t AFULL_CNT  = ptr_t'(AFULL_LVL);
  localparam ptr_t AEMPTY_CNT = ptr_t'(AEMPTY_LVL);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  ptr_t                 wptr;
  ptr_t                 rptr;
  ptr_t                 count_next;
  logic                 wr_ok;
  logic                 rd_ok;
  logic [ADDR_SIZE-1:0] waddr;
  logic [ADDR_SIZE-1:0] raddr;

  // Acceptance looks only at the registered flags, so a full FIFO refuses a
  // write even when a read frees a slot on the same edge (and vice versa).
  assign wr_ok = winc & ~wfull;
  assign rd_ok = rinc & ~rempty;
  assign waddr = wptr[ADDR_SIZE-1:0];
  assign raddr = rptr[ADDR_SIZE-1:0];

  always_comb begin
    // NOTE: default assignment first so every path drives count_next; no latch.
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + ptr_t'(1);
      2'b01:   count_next = count - ptr_t'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      walmost_full  <= 1'b0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + ptr_t'(1);
      if (rd_ok) rptr <= rptr + ptr_t'(1);
      count         <= count_next;
      wfull         <= (count_next == FULL_CNT);
      walmost_full  <= (count_next >= AFULL_CNT);
      rempty        <= (count_next == '0);
      ralmost_empty <= (count_next <= AEMPTY_CNT);
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end

  // NOTE: storage array has no reset; stale words are unreachable once the
  // pointers are cleared, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[waddr] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = rempty ? '0 : mem[raddr];
    end else begin : g_registered
      always_ff @(posedge clk) begin
        if (rst)        rdata <= '0;
        else if (rd_ok) rdata <= mem[raddr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: one registered-read and one fall-through
// instance share stimulus and are compared against a queue-based model.
`timescale 1ns/1ps

module tb_sync_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int AEMPTY = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wdata;
  logic       winc;
  logic       rinc;

  logic [7:0] rdata0, rdata1;
  logic       wfull0, walmost_full0, rempty0, ralmost_empty0, overflow0, underflow0;
  logic       wfull1, walmost_full1, rempty1, ralmost_empty1, overflow1, underflow1;
  logic [4:0] count0, count1;

  sync_fifo #(.DATA_SIZE(8), .ADDR_SIZE(4), .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPTY), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .rdata(rdata0),
    .wfull(wfull0), .walmost_full(walmost_full0), .rempty(rempty0),
    .ralmost_empty(ralmost_empty0), .count(count0), .overflow(overflow0), .underflow(underflow0)
  );

  sync_fifo #(.DATA_SIZE(8), .ADDR_SIZE(4), .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPTY), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .rdata(rdata1),
    .wfull(wfull1), .walmost_full(walmost_full1), .rempty(rempty1),
    .ralmost_empty(ralmost_empty1), .count(count1), .overflow(overflow1), .underflow(underflow1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: stored words, sticky error bits, and words owed to the
  // registered-read output in the order they were read.
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  bit         armed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and advance the model to
  // the state the DUT must hold after the next rising edge.
  task automatic step(input bit r, input bit w, input bit rd, input logic [7:0] d);
    bit full, empty;
    @(negedge clk);
    rst   = r;
    winc  = w;
    rinc  = rd;
    wdata = d;
    if (r) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      armed = 1'b1;
    end else begin
      full  = (model_q.size() == DEPTH);
      empty = (model_q.size() == 0);
      if (w && full)  m_ovf = 1'b1;
      if (rd && empty) m_unf = 1'b1;
      if (rd && !empty) exp_q.push_back(model_q.pop_front());
      if (w && !full) model_q.push_back(d);
    end
  endtask

  function automatic logic [10:0] expected_status();
    int sz = model_q.size();
    return {5'(sz), sz == DEPTH, sz >= AFULL, sz == 0, sz <= AEMPTY, m_ovf, m_unf};
  endfunction

  // Monitor: status of both instances every cycle, registered read data on
  // each accepted read, fall-through data whenever the FIFO is non-empty.
  initial begin
    bit fire0;
    forever begin
      @(posedge clk);
      fire0 = armed && !rst && rinc && (rempty0 === 1'b0);
      #1;
      if (armed) begin
        check("status_reg", {count0, wfull0, walmost_full0, rempty0, ralmost_empty0, overflow0, underflow0},
              expected_status());
        check("status_fwft", {count1, wfull1, walmost_full1, rempty1, ralmost_empty1, overflow1, underflow1},
              expected_status());
        if (fire0) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL rdata_reg: got %0h expected no read at %0t", rdata0, $time);
          end else begin
            check("rdata_reg", rdata0, exp_q.pop_front());
          end
        end
        if (model_q.size() != 0) check("rdata_fwft", rdata1, model_q[0]);
      end
    end
  end

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = '0;

    // Reset state, including the registered read data.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("reset_rdata_reg", rdata0, 8'h00);
    check("reset_rempty", rempty0, 1'b1);

    // Fill to full, then one rejected write of 0xAA.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(i));
    step(0, 1, 0, 8'hAA);
    step(0, 0, 0, 0);
    check("overflow_sticky", overflow0, 1'b1);

    // Drain in order, then one rejected read.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("underflow_sticky", underflow0, 1'b1);

    // Fall-through: first word visible one cycle after the write, no read needed.
    step(1, 0, 0, 0);
    step(0, 1, 0, 8'h5C);
    step(0, 0, 0, 0);
    check("fwft_first_word", rdata1, 8'h5C);
    check("fwft_not_empty", rempty1, 1'b0);
    step(0, 0, 1, 0);

    // Steady state at count 8 with simultaneous traffic; pointers wrap twice.
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(i));
    for (int i = 0; i < 40; i++) step(0, 1, 1, 8'(8 + i));
    step(0, 0, 0, 0);
    check("steady_count", count0, 5'd8);

    // Full plus read: write refused, read taken.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(48 + i));
    step(0, 1, 1, 8'hEE);
    step(0, 0, 0, 0);
    check("full_plus_read_count", count0, 5'd15);

    // Empty plus write: read refused, write taken.
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0);
    step(0, 1, 1, 8'h77);
    step(0, 0, 0, 0);
    check("empty_plus_write_count", count0, 5'd1);

    // Reset at count 5 with both requests asserted.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(i + 8'h30));
    step(1, 1, 1, 8'h99);
    step(0, 0, 0, 0);
    check("midop_reset_count", count0, 5'd0);
    check("midop_reset_flags", {rempty0, overflow0, underflow0}, 3'b100);

    // Randomized traffic with shifting write/read bias and rare resets.
    for (int i = 0; i < 1500; i++) begin
      int wp;
      case ((i / 250) % 3)
        0:       wp = 80;
        1:       wp = 25;
        default: wp = 55;
      endcase
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 99) < wp,
           $urandom_range(0, 99) < (105 - wp),
           8'($urandom));
    end

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    check("pending_reads", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
